// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR port arbiter slice: FSM state encoding,
// MCB command instruction codes, frame buffer base addresses and small
// address/length helpers.
package ddr_pkg;

  typedef enum logic [3:0] {
    ST_CALIB    = 4'd0,
    ST_FLUSH    = 4'd1,
    ST_ARB      = 4'd2,
    ST_WR_FILL  = 4'd3,
    ST_WR_CMD   = 4'd4,
    ST_RD_CMD   = 4'd5,
    ST_RD_DRAIN = 4'd6
  } state_t;

  localparam logic [2:0] INSTR_WR = 3'b000;
  localparam logic [2:0] INSTR_RD = 3'b001;

  localparam logic [29:0] FRAME0 = 30'd0;
  localparam logic [29:0] FRAME1 = 30'd5242880;

  // MCB byte addresses are word aligned; low two bits are dropped.
  function automatic logic [29:0] word_align(input logic [29:0] a);
    return a & ~30'd3;
  endfunction

  // Burst length field is words-minus-one; 7 bits so 63 -> 64 fits.
  function automatic logic [6:0] burst_words(input logic [5:0] len);
    return {1'b0, len} + 7'd1;
  endfunction

endpackage

// File: rtl/ddr_burst_counter.sv
// 7-bit load/decrement counter with zero flag, used by the arbiter to
// count write-fill words, read-drain pops and flush pops.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   load, load_val load the count (has priority over dec)
//   dec            decrement by one (ignored at zero)
//   count, zero    current count and count==0 flag
module ddr_burst_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [6:0] load_val,
  input  logic       dec,
  output logic [6:0] count,
  output logic       zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 7'd1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares one 32-bit MCB user port between a render writer and a display
// reader. Reads have priority; after MAX_RD_RUN consecutive read grants
// with a write pending, one write grant is forced. After calibration the
// MCB read FIFO is flushed of stale words (e.g. from a reset mid-burst).
// Ports:
//   clk, reset, mem_calib_done           clock, async reset, MCB calib done
//   rd_req/addr/len, rd_ack, rd_data/valid display read requester
//   wr_req/addr/len, wr_ack, wr_data/pop   render write requester
//   p_cmd_*, p_wr_*, p_rd_*                MCB user port
//   busy, state_dbg                        status for LEDs
module ddr_port_arbiter
  import ddr_pkg::*;
#(
  parameter int MAX_RD_RUN  = 4,
  parameter int FLUSH_LIMIT = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_calib_done,
  input  logic        rd_req,
  input  logic [29:0] rd_addr,
  input  logic [5:0]  rd_len,
  output logic        rd_ack,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        wr_req,
  input  logic [29:0] wr_addr,
  input  logic [5:0]  wr_len,
  output logic        wr_ack,
  input  logic [31:0] wr_data,
  output logic        wr_pop,
  output logic        p_cmd_en,
  output logic [2:0]  p_cmd_instr,
  output logic [5:0]  p_cmd_bl,
  output logic [29:0] p_cmd_byte_addr,
  input  logic        p_cmd_full,
  output logic        p_wr_en,
  output logic [31:0] p_wr_data,
  output logic [3:0]  p_wr_mask,
  input  logic        p_wr_full,
  input  logic        p_wr_empty,
  output logic        p_rd_en,
  input  logic [31:0] p_rd_data,
  input  logic        p_rd_empty,
  output logic        busy,
  output logic [3:0]  state_dbg
);

  localparam int RUN_W = $clog2(MAX_RD_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RD_RUN);

  state_t            state;
  logic              calib_meta, calib_sync;
  logic [29:0]       addr_q;
  logic [5:0]        len_q;
  logic [RUN_W-1:0]  run;

  logic              rd_grant, wr_grant;
  logic              wr_beat, rd_beat, fl_beat, cmd_fire;
  logic              cnt_load, cnt_dec, cnt_zero, cnt_last;
  logic [6:0]        cnt_val, cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      calib_meta <= 1'b0;
      calib_sync <= 1'b0;
    end else begin
      calib_meta <= mem_calib_done;
      calib_sync <= calib_meta;
    end
  end

  assign rd_grant = (state == ST_ARB) && rd_req && !(wr_req && (run == RUN_MAX));
  assign wr_grant = (state == ST_ARB) && wr_req && !rd_grant;

  // FIFO strobes are qualified combinationally by full/empty so a stall
  // takes effect in the same cycle and no word is lost or over-popped.
  assign wr_beat  = (state == ST_WR_FILL)  && !p_wr_full  && !cnt_zero;
  assign rd_beat  = (state == ST_RD_DRAIN) && !p_rd_empty && !cnt_zero;
  assign fl_beat  = (state == ST_FLUSH)    && !p_rd_empty && !cnt_zero;
  assign cmd_fire = ((state == ST_WR_CMD) || (state == ST_RD_CMD)) && !p_cmd_full;

  assign cnt_load = rd_grant || wr_grant || ((state == ST_CALIB) && calib_sync);
  assign cnt_val  = (state == ST_CALIB) ? 7'(FLUSH_LIMIT) :
                    rd_grant            ? burst_words(rd_len) : burst_words(wr_len);
  assign cnt_dec  = wr_beat || rd_beat || fl_beat;
  assign cnt_last = (cnt == 7'd1);

  ddr_burst_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  assign p_wr_en         = wr_beat;
  assign wr_pop          = wr_beat;
  assign p_wr_data       = wr_beat ? wr_data : '0;
  assign p_wr_mask       = '0;
  assign p_rd_en         = rd_beat || fl_beat;
  assign p_cmd_en        = cmd_fire;
  assign p_cmd_instr     = (state == ST_RD_CMD) ? INSTR_RD : INSTR_WR;
  assign p_cmd_bl        = len_q;
  assign p_cmd_byte_addr = addr_q;
  assign state_dbg       = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_CALIB;
      rd_ack <= 1'b0;
      wr_ack <= 1'b0;
      busy   <= 1'b0;
      addr_q <= '0;
      len_q  <= '0;
      run    <= '0;
    end else begin
      rd_ack <= 1'b0;
      wr_ack <= 1'b0;
      busy   <= 1'b1;
      case (state)
        ST_CALIB: begin
          if (calib_sync) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (p_rd_empty && p_wr_empty) begin
            state <= ST_ARB;
            busy  <= 1'b0;
          end
        end
        ST_ARB: begin
          if (rd_grant) begin
            rd_ack <= 1'b1;
            addr_q <= word_align(rd_addr);
            len_q  <= rd_len;
            state  <= ST_RD_CMD;
            // The run only counts reads that overtook a pending write.
            if (!wr_req)              run <= '0;
            else if (run != RUN_MAX)  run <= run + 1'b1;
          end else if (wr_grant) begin
            wr_ack <= 1'b1;
            addr_q <= word_align(wr_addr);
            len_q  <= wr_len;
            run    <= '0;
            state  <= ST_WR_FILL;
          end else begin
            busy <= 1'b0;
            if (!wr_req) run <= '0;
          end
        end
        ST_WR_FILL: begin
          if (wr_beat && cnt_last) state <= ST_WR_CMD;
        end
        ST_WR_CMD: begin
          if (!p_cmd_full) begin
            state <= ST_ARB;
            busy  <= 1'b0;
          end
        end
        ST_RD_CMD: begin
          if (!p_cmd_full) state <= ST_RD_DRAIN;
        end
        ST_RD_DRAIN: begin
          if (rd_beat && cnt_last) begin
            state <= ST_ARB;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_CALIB;
      endcase
    end
  end

  // Flush pops never reach the display side: only drain pops are echoed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_beat;
      if (rd_beat) rd_data <= p_rd_data;
    end
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Self-checking bench for ddr_port_arbiter: an MCB port model (read FIFO
// fed from a synthetic memory on read commands), requester handshakes and
// logs of grants, commands, written and read words compared against
// expectations derived from the request stream.
module tb_ddr_port_arbiter;
  import ddr_pkg::*;

  localparam int MAX_RD_RUN  = 4;
  localparam int FLUSH_LIMIT = 63;

  logic        clk, reset, mem_calib_done;
  logic        rd_req, rd_ack, rd_valid;
  logic [29:0] rd_addr;
  logic [5:0]  rd_len;
  logic [31:0] rd_data;
  logic        wr_req, wr_ack, wr_pop;
  logic [29:0] wr_addr;
  logic [5:0]  wr_len;
  logic [31:0] wr_data;
  logic        p_cmd_en, p_cmd_full;
  logic [2:0]  p_cmd_instr;
  logic [5:0]  p_cmd_bl;
  logic [29:0] p_cmd_byte_addr;
  logic        p_wr_en, p_wr_full, p_wr_empty;
  logic [31:0] p_wr_data;
  logic [3:0]  p_wr_mask;
  logic        p_rd_en, p_rd_empty;
  logic [31:0] p_rd_data;
  logic        busy;
  logic [3:0]  state_dbg;

  ddr_port_arbiter #(.MAX_RD_RUN(MAX_RD_RUN), .FLUSH_LIMIT(FLUSH_LIMIT)) dut (
    .clk(clk), .reset(reset), .mem_calib_done(mem_calib_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_ack(wr_ack),
    .wr_data(wr_data), .wr_pop(wr_pop),
    .p_cmd_en(p_cmd_en), .p_cmd_instr(p_cmd_instr), .p_cmd_bl(p_cmd_bl),
    .p_cmd_byte_addr(p_cmd_byte_addr), .p_cmd_full(p_cmd_full),
    .p_wr_en(p_wr_en), .p_wr_data(p_wr_data), .p_wr_mask(p_wr_mask),
    .p_wr_full(p_wr_full), .p_wr_empty(p_wr_empty),
    .p_rd_en(p_rd_en), .p_rd_data(p_rd_data), .p_rd_empty(p_rd_empty),
    .busy(busy), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  instr;
    logic [5:0]  bl;
    logic [29:0] addr;
  } cmd_t;

  int          vectors, miscompares, rd_pops;
  logic [31:0] rd_fifo[$], wr_src[$], wr_log[$], rd_log[$];
  bit          ack_w_log[$];   // 1 = write grant, 0 = read grant
  cmd_t        cmd_log[$];
  logic        stop_bp;

  function automatic logic [31:0] mem_word(input logic [29:0] a, input int unsigned i);
    return ({2'b00, a} ^ (i * 32'h9E37_79B9)) + 32'h1357_2468;
  endfunction

  task automatic refresh();
    p_rd_empty = (rd_fifo.size() == 0);
    p_rd_data  = p_rd_empty ? 32'h0 : rd_fifo[0];
    wr_data    = (wr_src.size() != 0) ? wr_src[0] : 32'h0;
  endtask

  task automatic clear_logs();
    wr_log.delete(); rd_log.delete(); ack_w_log.delete(); cmd_log.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // MCB port model plus protocol checks, sampled at the falling edge and
  // applied just after the rising edge.
  task automatic monitor();
    logic s_rd, s_wr, s_cmd_rd;
    cmd_t c;
    forever begin
      @(negedge clk);
      s_rd = p_rd_en; s_wr = p_wr_en; s_cmd_rd = 1'b0;
      vectors++;
      if (p_rd_en && p_wr_en) begin
        miscompares++;
        $display("FAIL rw_exclusive: p_rd_en=%b p_wr_en=%b, required not both 1", p_rd_en, p_wr_en);
      end
      vectors++;
      if (wr_pop !== p_wr_en || (p_wr_en && p_wr_data !== wr_data)) begin
        miscompares++;
        $display("FAIL wr_path: wr_pop=%b p_wr_en=%b p_wr_data=%h, required pop==en and data %h",
                 wr_pop, p_wr_en, p_wr_data, wr_data);
      end
      vectors++;
      if ((p_wr_en && p_wr_full) || (p_cmd_en && p_cmd_full) || (p_rd_en && p_rd_empty) ||
          (p_wr_mask !== 4'h0) || (rd_ack && wr_ack)) begin
        miscompares++;
        $display("FAIL fifo_protocol: wr_en=%b/full=%b cmd_en=%b/full=%b rd_en=%b/empty=%b mask=%h acks=%b%b",
                 p_wr_en, p_wr_full, p_cmd_en, p_cmd_full, p_rd_en, p_rd_empty, p_wr_mask, rd_ack, wr_ack);
      end
      if (rd_ack)   ack_w_log.push_back(1'b0);
      if (wr_ack)   ack_w_log.push_back(1'b1);
      if (p_wr_en)  wr_log.push_back(p_wr_data);
      if (rd_valid) rd_log.push_back(rd_data);
      if (p_cmd_en) begin
        c = '{p_cmd_instr, p_cmd_bl, p_cmd_byte_addr};
        cmd_log.push_back(c);
        s_cmd_rd = (p_cmd_instr == INSTR_RD);
      end
      @(posedge clk); #1;
      if (s_rd && rd_fifo.size() != 0) begin
        void'(rd_fifo.pop_front());
        rd_pops++;
      end
      if (s_wr && wr_src.size() != 0) void'(wr_src.pop_front());
      if (s_cmd_rd)
        for (int unsigned i = 0; i < 32'(c.bl) + 32'd1; i++) rd_fifo.push_back(mem_word(c.addr, i));
      refresh();
    end
  endtask

  task automatic wait_idle(input int max_cycles, input string what);
    int k, idle;
    k = 0; idle = 0;
    while (idle < 3 && k < max_cycles) begin
      @(negedge clk);
      k++;
      if (!busy && !reset) idle++; else idle = 0;
    end
    vectors++;
    if (idle < 3) begin
      miscompares++;
      $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", what, busy, k);
    end
    @(posedge clk); #2;
  endtask

  task automatic request_read(input logic [29:0] a, input logic [5:0] l);
    int k;
    k = 0;
    rd_addr = a; rd_len = l; rd_req = 1'b1;
    while (!rd_ack && k < 300) begin @(negedge clk); k++; end
    vectors++;
    if (!rd_ack) begin
      miscompares++;
      $display("FAIL rd_ack_timeout: rd_ack=%b after %0d cycles, required 1", rd_ack, k);
    end
    @(posedge clk); #2;
    rd_req = 1'b0;
  endtask

  task automatic request_write(input logic [29:0] a, input logic [5:0] l);
    int k;
    k = 0;
    wr_addr = a; wr_len = l; wr_req = 1'b1;
    while (!wr_ack && k < 300) begin @(negedge clk); k++; end
    vectors++;
    if (!wr_ack) begin
      miscompares++;
      $display("FAIL wr_ack_timeout: wr_ack=%b after %0d cycles, required 1", wr_ack, k);
    end
    @(posedge clk); #2;
    wr_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [191:0] outs;
    reset = 1'b1;
    tick(2);
    outs = {rd_ack, rd_valid, rd_data, wr_ack, wr_pop, p_cmd_en, p_cmd_instr, p_cmd_bl,
            p_cmd_byte_addr, p_wr_en, p_wr_data, p_wr_mask, p_rd_en, busy, state_dbg};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, required all zero", outs);
    end
    reset = 1'b0;
    tick(1);
    vectors++;
    if (busy !== 1'b1 || state_dbg !== ST_CALIB) begin
      miscompares++;
      $display("FAIL reset_calib: busy=%b state=%0d, required busy=1 state=%0d", busy, state_dbg, ST_CALIB);
    end
  endtask

  task automatic test_calibration();
    int base;
    for (int i = 0; i < 3; i++) rd_fifo.push_back(32'hDEAD_0000 + 32'(i));
    refresh();
    base = rd_pops;
    clear_logs();
    tick(100);
    vectors++;
    if (rd_pops != base || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL calib_hold: pops=%0d busy=%b, required pops=0 busy=1", rd_pops - base, busy);
    end
    mem_calib_done = 1'b1;
    wait_idle(200, "calib");
    vectors++;
    if (rd_pops - base != 3 || rd_log.size() != 0 || busy !== 1'b0 || rd_fifo.size() != 0) begin
      miscompares++;
      $display("FAIL calib_flush: pops=%0d rd_valid=%0d busy=%b left=%0d, required 3/0/0/0",
               rd_pops - base, rd_log.size(), busy, rd_fifo.size());
    end
  endtask

  task automatic test_single_write();
    clear_logs();
    for (int i = 1; i <= 4; i++) wr_src.push_back(32'(i));
    refresh();
    request_write(30'h103, 6'd3);
    wait_idle(200, "single_write");
    vectors++;
    if (ack_w_log.size() != 1 || ack_w_log[0] != 1'b1) begin
      miscompares++;
      $display("FAIL single_write_ack: grants=%0d, required one write grant", ack_w_log.size());
    end
    vectors++;
    if (wr_log.size() != 4 || wr_log[0] !== 32'd1 || wr_log[1] !== 32'd2 ||
        wr_log[2] !== 32'd3 || wr_log[3] !== 32'd4) begin
      miscompares++;
      $display("FAIL single_write_data: %0d words %p, required 1,2,3,4", wr_log.size(), wr_log);
    end
    vectors++;
    if (cmd_log.size() != 1 || cmd_log[0].instr !== INSTR_WR || cmd_log[0].bl !== 6'd3 ||
        cmd_log[0].addr !== 30'h100) begin
      miscompares++;
      $display("FAIL single_write_cmd: %0d cmds, first %p, required one instr=0 bl=3 addr=100",
               cmd_log.size(), cmd_log);
    end
  endtask

  task automatic test_single_read();
    logic ok;
    clear_logs();
    request_read(FRAME1, 6'd7);
    wait_idle(200, "single_read");
    vectors++;
    if (cmd_log.size() != 1 || cmd_log[0].instr !== INSTR_RD || cmd_log[0].bl !== 6'd7 ||
        cmd_log[0].addr !== 30'h50_0000) begin
      miscompares++;
      $display("FAIL single_read_cmd: %0d cmds %p, required one instr=1 bl=7 addr=500000",
               cmd_log.size(), cmd_log);
    end
    ok = (rd_log.size() == 8);
    for (int unsigned i = 0; i < 8 && ok; i++)
      if (rd_log[i] !== mem_word(30'h50_0000, i)) ok = 1'b0;
    vectors++;
    if (!ok || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_read_data: %0d words busy=%b, required 8 in-order words, busy=0",
               rd_log.size(), busy);
    end
  endtask

  task automatic test_starvation();
    logic [5:0] got, exp;
    int k;
    clear_logs();
    wr_src.push_back($urandom);
    refresh();
    rd_addr = FRAME0 + 30'h40; rd_len = 6'd1; wr_addr = 30'h200; wr_len = 6'd0;
    rd_req = 1'b1; wr_req = 1'b1;
    k = 0;
    while (ack_w_log.size() < 6 && k < 1000) begin
      tick(1);
      k++;
      if (wr_req && ack_w_log.size() != 0 && ack_w_log[ack_w_log.size()-1]) wr_req = 1'b0;
    end
    rd_req = 1'b0; wr_req = 1'b0;
    wait_idle(200, "starvation");
    got = '0; exp = '0;
    for (int i = 0; i < 6; i++) begin
      exp[i] = (i == MAX_RD_RUN);
      if (i < ack_w_log.size()) got[i] = ack_w_log[i];
    end
    vectors++;
    if (ack_w_log.size() != 6 || got !== exp) begin
      miscompares++;
      $display("FAIL starvation_order: %0d grants, order(lsb first, 1=W)=%b, required %b",
               ack_w_log.size(), got, exp);
    end
    vectors++;
    if (rd_log.size() != 10 || wr_log.size() != 1 || cmd_log.size() != 6) begin
      miscompares++;
      $display("FAIL starvation_traffic: rd=%0d wr=%0d cmds=%0d, required 10/1/6",
               rd_log.size(), wr_log.size(), cmd_log.size());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp[$];
    logic [29:0] a;
    int n0, k;
    logic ok;
    clear_logs();
    a = 30'($urandom);
    for (int i = 0; i < 8; i++) begin
      exp.push_back($urandom);
      wr_src.push_back(exp[i]);
    end
    refresh();
    p_cmd_full = 1'b1;
    request_write(a, 6'd7);
    k = 0;
    while (wr_log.size() < 3 && k < 100) begin tick(1); k++; end
    p_wr_full = 1'b1;
    n0 = wr_log.size();
    tick(5);
    vectors++;
    if (wr_log.size() != n0) begin
      miscompares++;
      $display("FAIL bp_wr_stall: pops while full=%0d, required 0", wr_log.size() - n0);
    end
    p_wr_full = 1'b0;
    k = 0;
    while (wr_log.size() < 8 && k < 100) begin tick(1); k++; end
    tick(3);
    vectors++;
    if (cmd_log.size() != 0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_cmd_hold: cmds=%0d busy=%b while cmd_full, required 0/1", cmd_log.size(), busy);
    end
    p_cmd_full = 1'b0;
    wait_idle(100, "backpressure");
    vectors++;
    if (cmd_log.size() != 1 || cmd_log[0].instr !== INSTR_WR || cmd_log[0].bl !== 6'd7 ||
        cmd_log[0].addr !== word_align(a)) begin
      miscompares++;
      $display("FAIL bp_cmd: %0d cmds %p, required one write bl=7 addr=%h", cmd_log.size(), cmd_log, word_align(a));
    end
    ok = (wr_log.size() == 8);
    for (int i = 0; i < 8 && ok; i++) if (wr_log[i] !== exp[i]) ok = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bp_data: %0d words %p, required %p", wr_log.size(), wr_log, exp);
    end
  endtask

  task automatic test_reset_mid_drain();
    int base, nv, k;
    clear_logs();
    base = rd_pops;
    request_read(FRAME1 + 30'h800, 6'd7);
    k = 0;
    while (rd_pops - base < 2 && k < 100) begin tick(1); k++; end
    reset = 1'b1;
    #1;
    vectors++;
    if ({p_rd_en, rd_valid, p_cmd_en, p_wr_en, wr_pop, rd_ack, wr_ack, busy} !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset_strobes: rd_en=%b rd_valid=%b cmd_en=%b wr_en=%b busy=%b, required 0",
               p_rd_en, rd_valid, p_cmd_en, p_wr_en, busy);
    end
    vectors++;
    if (rd_fifo.size() != 6 || rd_pops - base != 2) begin
      miscompares++;
      $display("FAIL mid_reset_point: popped=%0d left=%0d, required 2/6", rd_pops - base, rd_fifo.size());
    end
    nv = rd_log.size();
    mem_calib_done = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(5);
    mem_calib_done = 1'b1;
    wait_idle(300, "recalib");
    vectors++;
    if (rd_pops - base != 8 || rd_log.size() != nv || rd_fifo.size() != 0) begin
      miscompares++;
      $display("FAIL recalib_flush: popped=%0d new_valid=%0d left=%0d, required 8/0/0",
               rd_pops - base, rd_log.size() - nv, rd_fifo.size());
    end
  endtask

  task automatic test_random();
    cmd_t        exp_cmd[$];
    logic [31:0] exp_wr[$], exp_rd[$];
    logic [29:0] a;
    logic [5:0]  l;
    logic        ok;
    clear_logs();
    stop_bp = 1'b0;
    fork
      begin
        while (!stop_bp) begin
          tick(1);
          p_wr_full  = ($urandom_range(0, 3) == 0);
          p_cmd_full = ($urandom_range(0, 3) == 0);
        end
        p_wr_full = 1'b0; p_cmd_full = 1'b0;
      end
      begin
        for (int t = 0; t < 12; t++) begin
          a = 30'($urandom);
          l = (t < 2) ? 6'd63 : 6'($urandom_range(0, 63));
          if (t % 2 == 0 || $urandom_range(0, 1) == 1) begin
            for (int unsigned i = 0; i < 32'(l) + 32'd1; i++) begin
              exp_wr.push_back($urandom);
              wr_src.push_back(exp_wr[exp_wr.size()-1]);
            end
            refresh();
            exp_cmd.push_back('{INSTR_WR, l, a & ~30'd3});
            request_write(a, l);
          end else begin
            for (int unsigned i = 0; i < 32'(l) + 32'd1; i++) exp_rd.push_back(mem_word(a & ~30'd3, i));
            exp_cmd.push_back('{INSTR_RD, l, a & ~30'd3});
            request_read(a, l);
          end
          wait_idle(500, "random");
        end
        stop_bp = 1'b1;
      end
    join
    tick(2);
    ok = (cmd_log.size() == exp_cmd.size());
    for (int i = 0; i < exp_cmd.size() && ok; i++)
      if (cmd_log[i].instr !== exp_cmd[i].instr || cmd_log[i].bl !== exp_cmd[i].bl ||
          cmd_log[i].addr !== exp_cmd[i].addr) ok = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL random_cmds: got %0d cmds, required %0d matching", cmd_log.size(), exp_cmd.size());
    end
    ok = (wr_log.size() == exp_wr.size());
    for (int i = 0; i < exp_wr.size() && ok; i++) if (wr_log[i] !== exp_wr[i]) ok = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL random_wr_data: got %0d words, required %0d matching", wr_log.size(), exp_wr.size());
    end
    ok = (rd_log.size() == exp_rd.size());
    for (int i = 0; i < exp_rd.size() && ok; i++) if (rd_log[i] !== exp_rd[i]) ok = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL random_rd_data: got %0d words, required %0d matching", rd_log.size(), exp_rd.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vectors = 0; miscompares = 0; rd_pops = 0;
    reset = 1'b1; mem_calib_done = 1'b0;
    rd_req = 1'b0; rd_addr = '0; rd_len = '0;
    wr_req = 1'b0; wr_addr = '0; wr_len = '0;
    p_cmd_full = 1'b0; p_wr_full = 1'b0; p_wr_empty = 1'b1;
    stop_bp = 1'b0;
    refresh();
    fork
      monitor();
    join_none
    test_reset();
    test_calibration();
    test_single_write();
    test_single_read();
    test_starvation();
    test_backpressure();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ddr_port_arbiter.md
Name: ddr_port_arbiter

Overview:
- Shares one MCB user port (32-bit, bidirectional) between two requesters: a render writer that stores colour words into the back frame buffer, and a display reader that prefetches the front frame buffer.
- Reads have priority, so the display FIFO never underruns. A starvation counter guarantees the writer progress.
- Sits between the pixel/colour pipeline, the VGA prefetch FIFO and the MCB port pins. It sequences command issue, write-FIFO fill and read-FIFO drain for each burst.

Parameters:
- MAX_RD_RUN, 4, consecutive read grants allowed while wr_req is pending before one write grant is forced.
- FLUSH_LIMIT, 63, maximum stale words popped from p_rd FIFO in FLUSH state.

Ports:
- clk  in  1  system clock, same domain as MCB user port.
- reset  in  1  asynchronous, active-high.
- mem_calib_done  in  1  MCB calibration done; asynchronous, 2-flop synchronised internally.
- rd_req  in  1  display read request; held until rd_ack.
- rd_addr  in  30  byte address; bits [1:0] ignored and forced to 0.
- rd_len  in  6  burst length minus 1 (0..63 = 1..64 words).
- rd_ack  out  1  one-cycle pulse when read burst granted.
- rd_data  out  32  read word to display FIFO.
- rd_valid  out  1  rd_data valid this cycle.
- wr_req  in  1  render write request; held until wr_ack.
- wr_addr  in  30  byte address, bits [1:0] forced to 0.
- wr_len  in  6  burst length minus 1.
- wr_ack  out  1  one-cycle pulse when write burst granted.
- wr_data  in  32  current write word; must be valid whenever wr_pop could assert.
- wr_pop  out  1  wr_data consumed this cycle.
- p_cmd_en  out  1
- p_cmd_instr  out  3  000 write, 001 read.
- p_cmd_bl  out  6
- p_cmd_byte_addr  out  30
- p_cmd_full  in  1
- p_wr_en  out  1
- p_wr_data  out  32
- p_wr_mask  out  4  constant 0.
- p_wr_full  in  1
- p_wr_empty  in  1
- p_rd_en  out  1
- p_rd_data  in  32
- p_rd_empty  in  1
- busy  out  1  high in any state except ARB.
- state_dbg  out  4  current state encoding, for LEDs.

Behaviour:
- Reset values: all outputs 0, state = CALIB, run counter 0, word counter 0.
- CALIB:
  - Stay until the synchronised calib_done is 1.
  - Then go to FLUSH.
- FLUSH:
  - Assert p_rd_en while !p_rd_empty and the flush count is below FLUSH_LIMIT.
  - Go to ARB when p_rd_empty and p_wr_empty are both 1.
  - This covers a reset asserted mid-burst, which leaves stale MCB FIFO contents.
- ARB: evaluated every cycle.
  - Read grant: rd_req && !(wr_req && run == MAX_RD_RUN). Pulse rd_ack, latch addr/len, go to RD_CMD, run += 1 (saturating).
  - Write grant: wr_req and no read grant. Pulse wr_ack, latch addr/len, clear run, go to WR_FILL.
  - If wr_req is low, run is cleared.
  - Simultaneous rd_req and wr_req: read wins unless run == MAX_RD_RUN.
- WR_FILL:
  - Each cycle with !p_wr_full: p_wr_en = 1, p_wr_data = wr_data, wr_pop = 1, word count += 1.
  - When p_wr_full is high, p_wr_en = wr_pop = 0 (stall, no data lost).
  - After len+1 words, go to WR_CMD.
- WR_CMD:
  - When !p_cmd_full: one-cycle p_cmd_en with instr 000, bl = len, latched addr; go to ARB.
  - Otherwise hold state with p_cmd_en = 0.
- RD_CMD:
  - Same as WR_CMD with instr 001; then go to RD_DRAIN.
- RD_DRAIN:
  - p_rd_en = !p_rd_empty.
  - rd_data/rd_valid are registered copies of p_rd_data/p_rd_en, so there is 1 cycle latency from pop to rd_valid.
  - After len+1 pops, go to ARB. The final rd_valid appears in the first ARB cycle.
- Grant latency: rd_req high in ARB gives p_cmd_en 1 cycle later (if !p_cmd_full), so the first rd_valid comes no earlier than cmd + MCB latency + 1.
- Width rules:
  - Word counter is 7 bits, so a len of 63 does not wrap.
  - The latched address never increments inside the block; requesters own address stepping.
- Reset asserted in any state: immediate return to CALIB, all strobes drop the same edge.
- Never assert p_rd_en and p_wr_en in the same cycle.

Decomposition:
- Shared package (ddr_pkg): state encodings, MCB instruction constants (INSTR_WR = 3'b000, INSTR_RD = 3'b001), frame base addresses (FRAME0 = 0, FRAME1 = 5242880).
- One natural sub-module: ddr_burst_counter, a 7-bit load/decrement/zero-flag counter shared by WR_FILL, RD_DRAIN and FLUSH.

Test Plan:
- Calibration: hold mem_calib_done = 0 for 100 cycles then 1, rd FIFO model preloaded with 3 stale words -> exactly 3 p_rd_en pulses in FLUSH, then ARB, busy = 0, no rd_valid.
- Single write: wr_req, wr_addr = 0x103, wr_len = 3 ->
  - wr_ack pulse, 4 wr_pop/p_wr_en cycles with data 1..4;
  - then one p_cmd_en with instr 000, bl = 3, addr 0x100.
- Single read: rd_req, rd_addr = 0x500000, rd_len = 7, model returns 8 words -> one p_cmd_en with instr 001, bl = 7; 8 rd_valid words in order; back in ARB.
- Starvation: rd_req held continuously and wr_req asserted, MAX_RD_RUN = 4 -> grant order R,R,R,R,W,R...
- Backpressure: p_wr_full high 5 cycles mid-fill, p_cmd_full high 3 cycles -> no pop while full, word count still len+1, exactly one p_cmd_en after p_cmd_full drops.
- Reset mid RD_DRAIN after 2 of 8 words -> outputs 0 the same cycle; after recalibration FLUSH drains the 6 remaining words; no rd_valid produced for them.
